// File: rtl/regfile_cmd_ctrl.sv
// Byte-stream command parser for the register file: decodes write/read frames from the
// UART receiver, issues single-cycle register strobes and returns read data to the transmitter.
module regfile_cmd_ctrl #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    ADDR_WIDTH    = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD        = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD        = 8'hBB,
    parameter int                    FRAME_TIMEOUT = 1024,
    parameter int                    RD_TIMEOUT    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  CMD_ERR
);

    localparam int MAX_TMO = (FRAME_TIMEOUT > RD_TIMEOUT) ? FRAME_TIMEOUT : RD_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_TMO + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      tmo_cnt;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  addr_ok;

    // A byte is a legal address only if no bits above the address field are set.
    assign addr_ok = (RX_P_DATA >> ADDR_WIDTH) == '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            tx_buf    <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
        end else begin
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            TX_D_VLD <= 1'b0;
            CMD_ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == WR_CMD) begin
                            state <= WR_ADDR;
                        end else if (RX_P_DATA == RD_CMD) begin
                            state <= RD_ADDR;
                        end else begin
                            CMD_ERR <= 1'b1;
                        end
                    end
                end
                WR_ADDR, RD_ADDR: begin
                    if (RX_D_VLD) begin
                        tmo_cnt <= '0;
                        if (addr_ok) begin
                            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            if (state == WR_ADDR) begin
                                state <= WR_DATA;
                            end else begin
                                RdEn  <= 1'b1;
                                state <= RD_WAIT;
                            end
                        end else begin
                            CMD_ERR <= 1'b1;
                            state   <= IDLE;
                        end
                    end else if (tmo_cnt == FRAME_LAST) begin
                        CMD_ERR <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else if (tmo_cnt == FRAME_LAST) begin
                        CMD_ERR <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RD_WAIT: begin
                    // Counter starts at zero in the RdEn cycle, so the error lands RD_TIMEOUT cycles after RdEn.
                    if (RX_D_VLD) begin
                        CMD_ERR <= 1'b1;
                    end
                    if (RdData_Valid) begin
                        tx_buf <= RdData;
                        state  <= TX_SEND;
                    end else if (tmo_cnt == RD_LAST) begin
                        CMD_ERR <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                TX_SEND: begin
                    if (RX_D_VLD) begin
                        CMD_ERR <= 1'b1;
                    end
                    if (!TX_BUSY) begin
                        TX_P_DATA <= tx_buf;
                        TX_D_VLD  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Self-checking bench for regfile_cmd_ctrl: frame-level reference model predicts every
// strobe, TX byte and error pulse with its cycle; a monitor logs what the DUT produced.
module tb_regfile_cmd_ctrl;

    localparam int FT = 1024;
    localparam int RT = 8;
    localparam logic [7:0] WR = 8'hAA;
    localparam logic [7:0] RD = 8'hBB;
    localparam int EW = 38;
    localparam logic [1:0] K_WR = 2'd0;
    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_TX = 2'd2;
    localparam logic [1:0] K_ER = 2'd3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic       WrEn, RdEn, TX_D_VLD, CMD_ERR;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;
    logic [7:0] RdData = 8'h00;
    logic       RdData_Valid = 1'b0;
    logic       TX_BUSY = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    logic [7:0]    ref_regs [16] = '{default: 8'h00};
    logic [7:0]    rf_mem [16] = '{default: 8'h00};
    logic          rf_withhold = 1'b0;

    regfile_cmd_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .WR_CMD(WR), .RD_CMD(RD),
        .FRAME_TIMEOUT(FT), .RD_TIMEOUT(RT)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .CMD_ERR(CMD_ERR)
    );

    // Clock/reset
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Register file responder: read data returns one cycle after RdEn.
    always @(posedge CLK) begin
        RdData_Valid <= 1'b0;
        if (WrEn) rf_mem[Address] <= WrData;
        if (RdEn && !rf_withhold) begin
            RdData       <= rf_mem[Address];
            RdData_Valid <= 1'b1;
        end
    end

    function automatic logic [EW-1:0] ev(input logic [1:0] k, input int c,
                                         input logic [7:0] a, input logic [7:0] d);
        return {k, c[19:0], a, d};
    endfunction

    function automatic string kname(input logic [1:0] k);
        case (k)
            K_WR: return "wr_event";
            K_RD: return "rd_event";
            K_TX: return "tx_event";
            default: return "err_event";
        endcase
    endfunction

    // Monitor
    always @(negedge CLK) begin
        if (WrEn)     obs_q.push_back(ev(K_WR, cyc, {4'h0, Address}, WrData));
        if (RdEn)     obs_q.push_back(ev(K_RD, cyc, {4'h0, Address}, 8'h00));
        if (TX_D_VLD) obs_q.push_back(ev(K_TX, cyc, 8'h00, TX_P_DATA));
        if (CMD_ERR)  obs_q.push_back(ev(K_ER, cyc, 8'h00, 8'h00));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic exp_push(input logic [1:0] k, input int c, input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back(ev(k, c, a, d));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wren"}, WrEn, 1'b0);
        check({tag, "_rden"}, RdEn, 1'b0);
        check({tag, "_addr"}, Address, 4'h0);
        check({tag, "_wrdata"}, WrData, 8'h00);
        check({tag, "_txdata"}, TX_P_DATA, 8'h00);
        check({tag, "_txvld"}, TX_D_VLD, 1'b0);
        check({tag, "_err"}, CMD_ERR, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int g1, input int g2);
        int n;
        send_byte(WR);
        idle(g1);
        send_byte(a);
        idle(g2);
        n = cyc;
        send_byte(d);
        exp_push(K_WR, n + 1, a, d);
        ref_regs[a[3:0]] = d;
    endtask

    task automatic do_read(input logic [7:0] a, input int g, input int busy);
        int n, f, t;
        send_byte(RD);
        idle(g);
        n = cyc;
        if (busy > 0) TX_BUSY = 1'b1;
        send_byte(a);
        exp_push(K_RD, n + 1, a, 8'h00);
        idle(busy);
        f = cyc;
        TX_BUSY = 1'b0;
        t = ((f > n + 3) ? f : n + 3) + 1;
        exp_push(K_TX, t, 8'h00, ref_regs[a[3:0]]);
        while (cyc < t) idle(1);
    endtask

    task automatic do_bad_op(input logic [7:0] b);
        int n;
        n = cyc;
        send_byte(b);
        exp_push(K_ER, n + 1, 8'h00, 8'h00);
    endtask

    task automatic do_bad_addr(input logic [7:0] op, input logic [7:0] a);
        int n;
        send_byte(op);
        n = cyc;
        send_byte(a);
        exp_push(K_ER, n + 1, 8'h00, 8'h00);
    endtask

    initial begin
        int n, sel, nc;
        logic [7:0] b;

        RST = 1'b1;
        idle(3);
        check_outputs_zero("reset");
        RST = 1'b0;
        idle(2);

        // Basic write and read-back with no backpressure
        do_write(8'h05, 8'h3C, 0, 0);
        do_write(8'h02, 8'h81, 0, 0);
        do_read(8'h02, 0, 0);
        idle(2);
        check("addr_hold", Address, 4'h2);
        check("wrdata_hold", WrData, 8'h81);

        // TX backpressure
        do_read(8'h02, 1, 50);

        // Error cases
        do_bad_op(8'h55);
        do_bad_addr(WR, 8'h10);
        do_bad_addr(RD, 8'hFF);
        send_byte(WR);
        n = cyc;
        send_byte(8'h05);
        idle(FT + 3);
        exp_push(K_ER, n + FT + 1, 8'h00, 8'h00);

        // Last byte still accepted on the final allowed cycle
        do_write(8'h07, 8'h5A, 2, FT - 1);

        // Read data withheld
        rf_withhold = 1'b1;
        send_byte(RD);
        n = cyc;
        send_byte(8'h03);
        exp_push(K_RD, n + 1, 8'h03, 8'h00);
        exp_push(K_ER, n + 1 + RT, 8'h00, 8'h00);
        while (cyc < n + 2 + RT) idle(1);
        rf_withhold = 1'b0;
        idle(1);

        // Byte arriving while waiting to transmit is dropped with an error
        send_byte(RD);
        n = cyc;
        TX_BUSY = 1'b1;
        send_byte(8'h05);
        exp_push(K_RD, n + 1, 8'h05, 8'h00);
        idle(5);
        send_byte(8'h77);
        exp_push(K_ER, n + 7, 8'h00, 8'h00);
        idle(10);
        TX_BUSY = 1'b0;
        exp_push(K_TX, n + 18, 8'h00, ref_regs[5]);
        idle(3);

        // Reset in the middle of a frame
        send_byte(WR);
        send_byte(8'h05);
        RST = 1'b1;
        idle(1);
        check_outputs_zero("midreset");
        RST = 1'b0;
        do_bad_op(8'h3C);
        idle(2);

        // Back-to-back frames
        do_write(8'h01, 8'h11, 0, 0);
        do_write(8'h02, 8'h22, 0, 0);
        do_read(8'h01, 0, 0);

        // Randomized frames
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                do_write(8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (sel <= 6) begin
                do_read(8'($urandom_range(0, 15)), $urandom_range(0, 3),
                        ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0);
            end else if (sel == 7) begin
                b = 8'($urandom_range(0, 255));
                while (b == WR || b == RD) b = 8'($urandom_range(0, 255));
                do_bad_op(b);
            end else begin
                do_bad_addr(($urandom_range(0, 1) == 1) ? WR : RD, 8'($urandom_range(16, 255)));
            end
            idle($urandom_range(0, 2));
        end
        idle(10);

        // Scoreboard compare
        check("event_count", obs_q.size(), exp_q.size());
        nc = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nc; i++) begin
            check(kname(exp_q[i][EW-1:EW-2]), obs_q[i], exp_q[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
